// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl: execute-stage predication controller.
// Holds the committed NZCV flags and checks each instruction's condition field against them.
// Gates register, memory, PC and flag writes, and squashes the wrong-path instructions
// that follow a taken branch.
// Optional feature: define COND_STATS_EN to add the saturating ExecCnt/SkipCnt counters.
module cond_exec_ctrl #(
    parameter int unsigned BRANCH_SHADOW = 2
`ifdef COND_STATS_EN
    ,
    parameter int unsigned CNT_W         = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic [3:0]       CondE,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagWE,
    input  logic             RegWE,
    input  logic             MemWE,
    input  logic             PCSE,
    input  logic             NoWriteE,
    output logic [3:0]       Flags,
    output logic             CondExE,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             PCSrc,
    output logic             Squash,
    output logic             Undef
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SkipCnt
`endif
);

    // Shadow length loaded on a taken branch. Legal values are 1..7, so it fits in 3 bits.
    localparam logic [2:0] SHADOW_LOAD = 3'(BRANCH_SHADOW);

    typedef enum logic [0:0] {
        StIdle,
        StShadow
    } shadow_state_t;

    shadow_state_t state;
    logic [2:0]    shadow_cnt;

    logic flag_n, flag_z, flag_c, flag_v;
    logic ge;
    logic pass;
    logic in_shadow;
    logic cond_undef;
    logic advance;

    assign flag_n = Flags[3];
    assign flag_z = Flags[2];
    assign flag_c = Flags[1];
    assign flag_v = Flags[0];
    assign ge     = (flag_n == flag_v);

    // The condition is decoded from the committed flags only. ALUFlags is never used here.
    always_comb begin
        pass = 1'b0;
        case (CondE)
            4'h0: pass = flag_z;
            4'h1: pass = !flag_z;
            4'h2: pass = flag_c;
            4'h3: pass = !flag_c;
            4'h4: pass = flag_n;
            4'h5: pass = !flag_n;
            4'h6: pass = flag_v;
            4'h7: pass = !flag_v;
            4'h8: pass = flag_c & !flag_z;
            4'h9: pass = !(flag_c & !flag_z);
            4'hA: pass = ge;
            4'hB: pass = !ge;
            4'hC: pass = !flag_z & ge;
            4'hD: pass = !(!flag_z & ge);
            4'hE: pass = 1'b1;
            4'hF: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

    assign cond_undef = (CondE == 4'hF);
    assign in_shadow  = (state == StShadow);
    assign advance    = !StallE;

    // Gating has zero latency. While reset is high, every gated output is forced to 0.
    always_comb begin
        Squash   = ValidE & in_shadow & !reset;
        CondExE  = ValidE & pass & !Squash & !reset;
        Undef    = ValidE & cond_undef & !Squash & !reset;
        RegWrite = CondExE & RegWE & !NoWriteE;
        MemWrite = CondExE & MemWE;
        PCSrc    = CondExE & PCSE;
    end

    // Flags register and branch-shadow FSM. Both hold while the stage is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags      <= 4'b0000;
            state      <= StIdle;
            shadow_cnt <= 3'd0;
        end else if (advance) begin
            if (CondExE && FlagWE[1]) begin
                Flags[3:2] <= ALUFlags[3:2];
            end
            if (CondExE && FlagWE[0]) begin
                Flags[1:0] <= ALUFlags[1:0];
            end
            case (state)
                StIdle: begin
                    if (PCSrc) begin
                        shadow_cnt <= SHADOW_LOAD;
                        state      <= StShadow;
                    end
                end
                StShadow: begin
                    // Every instruction in the shadow is squashed, so PCSrc stays low here.
                    // Bubbles drain the counter as well.
                    shadow_cnt <= shadow_cnt - 3'd1;
                    if (shadow_cnt == 3'd1) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state      <= StIdle;
                    shadow_cnt <= 3'd0;
                end
            endcase
        end
    end

`ifdef COND_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count valid instructions that advance. Undef and squashed instructions count as skips.
    // Both counters saturate at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ExecCnt <= '0;
            SkipCnt <= '0;
        end else if (advance && ValidE) begin
            if (CondExE) begin
                if (ExecCnt != CNT_MAX) begin
                    ExecCnt <= ExecCnt + 1'b1;
                end
            end else begin
                if (SkipCnt != CNT_MAX) begin
                    SkipCnt <= SkipCnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// tb_cond_exec_ctrl: directed stimulus for cond_exec_ctrl.
// A behavioural model is checked against the DUT on every cycle, and a few literal
// checks fix the model's expected values.
module tb_cond_exec_ctrl;

    localparam int unsigned SHADOW = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       ValidE, StallE, RegWE, MemWE, PCSE, NoWriteE;
    logic [3:0] CondE, ALUFlags;
    logic [1:0] FlagWE;
    logic [3:0] Flags;
    logic       CondExE, RegWrite, MemWrite, PCSrc, Squash, Undef;
`ifdef COND_STATS_EN
    logic [15:0] ExecCnt, SkipCnt;
    logic [15:0] m_exec, m_skip;
`endif

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    // Model state: the committed flags and the number of wrong-path slots still to kill.
    logic [3:0] m_flags;
    int         m_shadow;

    cond_exec_ctrl #(
        .BRANCH_SHADOW(SHADOW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ValidE  (ValidE),
        .StallE  (StallE),
        .CondE   (CondE),
        .ALUFlags(ALUFlags),
        .FlagWE  (FlagWE),
        .RegWE   (RegWE),
        .MemWE   (MemWE),
        .PCSE    (PCSE),
        .NoWriteE(NoWriteE),
        .Flags   (Flags),
        .CondExE (CondExE),
        .RegWrite(RegWrite),
        .MemWrite(MemWrite),
        .PCSrc   (PCSrc),
        .Squash  (Squash),
        .Undef   (Undef)
`ifdef COND_STATS_EN
        ,
        .ExecCnt (ExecCnt),
        .SkipCnt (SkipCnt)
`endif
    );

    always #5 clk = ~clk;

    // Condition check done the ARM way: each even/odd pair shares one base test,
    // and the odd code is the inverse of the even one.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic bit m_squash();
        return ValidE && (m_shadow != 0);
    endfunction

    function automatic bit m_exec_ok();
        return ValidE && !m_squash() && cond_pass(CondE, m_flags);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each clock edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_flags  <= 4'b0000;
            m_shadow <= 0;
`ifdef COND_STATS_EN
            m_exec   <= 16'd0;
            m_skip   <= 16'd0;
`endif
        end else if (!StallE) begin
            if (m_exec_ok()) begin
                m_flags <= {FlagWE[1] ? ALUFlags[3:2] : m_flags[3:2],
                            FlagWE[0] ? ALUFlags[1:0] : m_flags[1:0]};
            end
            if (m_exec_ok() && PCSE) m_shadow <= SHADOW;
            else if (m_shadow > 0)   m_shadow <= m_shadow - 1;
`ifdef COND_STATS_EN
            if (ValidE) begin
                if (m_exec_ok()) m_exec <= (m_exec == 16'hFFFF) ? m_exec : m_exec + 16'd1;
                else             m_skip <= (m_skip == 16'hFFFF) ? m_skip : m_skip + 16'd1;
            end
`endif
        end
    end

    // Compare process, run away from the active edge
    always @(negedge clk) begin
        if (armed) begin
            if (reset) begin
                chk("rst_condexe", {31'd0, CondExE}, 32'd0);
                chk("rst_gated", {28'd0, RegWrite, MemWrite, PCSrc, Squash}, 32'd0);
                chk("rst_undef", {31'd0, Undef}, 32'd0);
                chk("rst_flags", {28'd0, Flags}, 32'd0);
            end else begin
                chk("flags", {28'd0, Flags}, {28'd0, m_flags});
                chk("squash", {31'd0, Squash}, {31'd0, m_squash()});
                chk("condexe", {31'd0, CondExE}, {31'd0, m_exec_ok()});
                chk("regwrite", {31'd0, RegWrite}, {31'd0, m_exec_ok() && RegWE && !NoWriteE});
                chk("memwrite", {31'd0, MemWrite}, {31'd0, m_exec_ok() && MemWE});
                chk("pcsrc", {31'd0, PCSrc}, {31'd0, m_exec_ok() && PCSE});
                chk("undef", {31'd0, Undef},
                    {31'd0, ValidE && !m_squash() && (CondE == 4'hF)});
`ifdef COND_STATS_EN
                chk("execcnt", {16'd0, ExecCnt}, {16'd0, m_exec});
                chk("skipcnt", {16'd0, SkipCnt}, {16'd0, m_skip});
`endif
            end
        end
    end

    // One instruction slot: drive just after the edge, and return at the next falling edge
    task automatic step(input logic v, input logic st, input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input logic rw, input logic mw, input logic pc,
                        input logic nw);
        @(posedge clk);
        #1;
        ValidE = v; StallE = st; CondE = c; ALUFlags = af; FlagWE = fw;
        RegWE = rw; MemWE = mw; PCSE = pc; NoWriteE = nw;
        @(negedge clk);
    endtask

    task automatic al_instr();
        step(1, 0, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        ValidE = 1; StallE = 0; CondE = 4'hE; RegWE = 1; MemWE = 1; PCSE = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ValidE = 0; PCSE = 0;
    endtask

    logic [3:0] pats [4];

    initial begin
        reset = 1'b1;
        ValidE = 1; StallE = 0; CondE = 4'hE; ALUFlags = 4'h0; FlagWE = 2'b00;
        RegWE = 1; MemWE = 1; PCSE = 1; NoWriteE = 0;
        armed = 1;
        do_reset();

        // 1: AL instruction right after reset
        al_instr();
        chk("t1_condexe", {31'd0, CondExE}, 32'd1);
        chk("t1_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("t1_flags", {28'd0, Flags}, 32'h0);

        // 2: CMP sets Z, then BEQ is taken
        step(1, 0, 4'hE, 4'b0100, 2'b11, 1, 0, 0, 1);
        chk("t2_cmp_regwrite", {31'd0, RegWrite}, 32'd0);
        step(1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0);
        chk("t2_flags", {28'd0, Flags}, 32'h4);
        chk("t2_pcsrc", {31'd0, PCSrc}, 32'd1);

        // 3: two shadow slots, then normal execution
        al_instr(); chk("t3_sq0", {31'd0, Squash}, 32'd1); chk("t3_rw0", {31'd0, RegWrite}, 32'd0);
        al_instr(); chk("t3_sq1", {31'd0, Squash}, 32'd1); chk("t3_rw1", {31'd0, RegWrite}, 32'd0);
        al_instr(); chk("t3_sq2", {31'd0, Squash}, 32'd0); chk("t3_rw2", {31'd0, RegWrite}, 32'd1);
        al_instr(); chk("t3_rw3", {31'd0, RegWrite}, 32'd1);

        // 4: taken branch, 3 stalled cycles, then 2 squashed instructions
        step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0);
        chk("t4_pcsrc", {31'd0, PCSrc}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 4'hE, 4'hF, 2'b11, 1, 0, 0, 0);
            chk("t4_stall_sq", {31'd0, Squash}, 32'd1);
        end
        al_instr(); chk("t4_sq0", {31'd0, Squash}, 32'd1);
        al_instr(); chk("t4_sq1", {31'd0, Squash}, 32'd1);
        al_instr(); chk("t4_after", {31'd0, Squash}, 32'd0);
        chk("t4_flags_held", {28'd0, Flags}, 32'h4);

        // Bubbles drain the shadow
        step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0);
        step(0, 0, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0);
        step(0, 0, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0);
        al_instr(); chk("bubble_drain", {31'd0, Squash}, 32'd0);

        // 5: each flag half updates on its own
        do_reset();
        step(1, 0, 4'hE, 4'b1011, 2'b10, 0, 0, 0, 0);
        step(1, 0, 4'hE, 4'b0111, 2'b01, 0, 0, 0, 0);
        chk("t5_nz", {28'd0, Flags}, 32'h8);
        al_instr();
        chk("t5_cv", {28'd0, Flags}, 32'hB);

        // 6: condition 1111 is undefined and must not touch the flags
        step(1, 0, 4'hF, 4'b0000, 2'b11, 1, 1, 0, 0);
        chk("t6_undef", {31'd0, Undef}, 32'd1);
        chk("t6_regwrite", {31'd0, RegWrite}, 32'd0);
        al_instr();
        chk("t6_flags", {28'd0, Flags}, 32'hB);

        // Every condition code under several flag patterns, checked by the model
        pats[0] = 4'b0000; pats[1] = 4'b0110; pats[2] = 4'b1001; pats[3] = 4'b1010;
        for (int p = 0; p < 4; p++) begin
            step(1, 0, 4'hE, pats[p], 2'b11, 0, 0, 0, 0);
            for (int c = 0; c < 16; c++) begin
                step(1, 0, 4'(c), 4'h0, 2'b00, 1, 1, 0, 0);
            end
        end
        // Flags 1010: N!=V and Z=0, so GT fails and LE passes
        step(1, 0, 4'hC, 4'h0, 2'b00, 1, 0, 0, 0);
        chk("gt_fail", {31'd0, CondExE}, 32'd0);
        step(1, 0, 4'hD, 4'h0, 2'b00, 1, 0, 0, 0);
        chk("le_pass", {31'd0, CondExE}, 32'd1);

        // Reset pulse in the middle of the shadow clears it at once
        step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0);
        al_instr();
        chk("t6_mid_sq", {31'd0, Squash}, 32'd1);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        al_instr();
        chk("t6_rst_sq", {31'd0, Squash}, 32'd0);
        chk("t6_rst_flags", {28'd0, Flags}, 32'h0);

        armed = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
